systolic_ctrl: RTL
==================

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, meaning array dimension (N×N MACs, N>=2).
REQ-002 SHALL have parameter ROW_W, default 16, meaning width of the row count and data address.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  meaning a pulse that requests one job; sampled only in IDLE.
REQ-006 SHALL have port rows  input  ROW_W  meaning M, the number of input vectors; captured on the accepted start.
REQ-007 SHALL have port busy  output  1  meaning a job is in progress.
REQ-008 SHALL have port done  output  1  meaning a one-cycle job-complete pulse.
REQ-009 SHALL have port w_rd_en  output  1  meaning a weight-memory read strobe (1-cycle read latency).
REQ-010 SHALL have port w_addr  output  $clog2(N)  meaning the weight-row address.
REQ-011 SHALL have port d_rd_en  output  1  meaning a data-memory read strobe (1-cycle read latency).
REQ-012 SHALL have port d_addr  output  ROW_W  meaning the data-vector address.
REQ-013 SHALL have ports load_weight, swap_weights, run  output  1 each  meaning broadcast MAC array controls.
REQ-014 SHALL have port acc_valid  output  1  meaning the bottom-row accumulators hold a finished result row.
REQ-015 SHALL have port acc_row  output  ROW_W  meaning the index of the result row qualified by acc_valid.

Function
Cycle 0 is the clock edge on which start is accepted.
REQ-016 SHALL implement states IDLE, LOAD, SWAP, RUN, DONE, with transitions IDLE->LOAD on start, LOAD->SWAP after N cycles, SWAP->RUN (M>0) or SWAP->DONE (M=0), RUN->DONE after the last acc_valid cycle, and DONE->IDLE.
REQ-017 SHALL assert w_rd_en in cycles 1..N with w_addr = N-1, N-2, ... 0 (bottom weight row first).
REQ-018 SHALL assert load_weight in cycles 2..N+1, i.e. w_rd_en delayed one cycle.
REQ-019 SHALL assert swap_weights for exactly cycle N+2, and never in the same cycle as load_weight.
REQ-020 SHALL assert d_rd_en in cycles N+3..N+2+M with d_addr = 0..M-1.
REQ-021 SHALL assert run continuously in cycles N+4..3N+M+2, covering the skew and drain.
REQ-022 SHALL assert acc_valid in cycles 3N+3..3N+M+2 with acc_row = 0..M-1.
REQ-023 SHALL pulse done in cycle 3N+M+3 when M>0, and in cycle N+3 when M=0.
REQ-024 SHALL hold busy high from cycle 1 through the done cycle inclusive.
REQ-025 SHALL ignore start while busy, and SHALL ignore a start coincident with done.
REQ-026 SHALL hold w_addr, d_addr and acc_row at 0 while their qualifiers are low.
REQ-027 SHALL count M up to 2^ROW_W-1 with no wrap of d_addr or acc_row within a job.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-job, asynchronously force state IDLE and drive all outputs to 0.
REQ-029 SHALL discard the interrupted job, resuming only on a new start after rst_n deasserts.

Configuration
REQ-030 SHALL, with SYSTOLIC_CTRL_PERF_EN defined, add output cycle_count[31:0], cleared on the accepted start, incremented every busy cycle, saturating at all-ones, and held after done until the next start.
REQ-031 SHALL, without SYSTOLIC_CTRL_PERF_EN, omit cycle_count and its logic entirely.

Verification
REQ-032 SHALL cover: N=4, rows=3, start pulse -> w_addr 3,2,1,0 in cycles 1-4, load_weight in 2-5, swap in 6, d_addr 0-2 in 7-9, run in 8-17, acc_valid in 15-17, done in 18.
REQ-033 SHALL cover: N=4, rows=0 -> LOAD and SWAP as above, no d_rd_en/run/acc_valid, done in cycle 7.
REQ-034 SHALL cover: start re-pulsed in cycles 5 and 18 of a rows=3 job -> both ignored, busy falls after cycle 18, no second job.
REQ-035 SHALL cover: rst_n low in cycle 10 of a rows=3 job -> all outputs 0 immediately, then start with rows=1 -> clean job with done in cycle 16.
REQ-036 SHALL cover: with SYSTOLIC_CTRL_PERF_EN, N=4, rows=3 -> cycle_count=18 after done, held until the next start.
REQ-037 SHALL cover: back-to-back jobs, start one cycle after done -> second job timing identical to the first.

Source files
------------

// File: rtl/systolic_ctrl_if.sv
// ---------------------------------------------------------------------------
// systolic_ctrl_if
// Purpose : bundles the job handshake and the memory / MAC-array control
//           signals of systolic_ctrl into one interface.
// Signals : start, rows              - job request (driven by the master)
//           busy, done                - job status
//           w_rd_en, w_addr           - weight memory read port
//           d_rd_en, d_addr           - data memory read port
//           load_weight, swap_weights,
//           run                       - broadcast MAC array controls
//           acc_valid, acc_row        - finished result row qualifier/index
//           cycle_count               - busy-cycle counter, only present
//                                       when SYSTOLIC_CTRL_PERF_EN is defined
// Modports: master - the job requester / observer
//           slave  - the controller itself
// ---------------------------------------------------------------------------
interface systolic_ctrl_if #(
  parameter int N     = 4,
  parameter int ROW_W = 16
) ();

  logic                 start;
  logic [ROW_W-1:0]     rows;
  logic                 busy;
  logic                 done;
  logic                 w_rd_en;
  logic [$clog2(N)-1:0] w_addr;
  logic                 d_rd_en;
  logic [ROW_W-1:0]     d_addr;
  logic                 load_weight;
  logic                 swap_weights;
  logic                 run;
  logic                 acc_valid;
  logic [ROW_W-1:0]     acc_row;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0]          cycle_count;
`endif

`ifdef SYSTOLIC_CTRL_PERF_EN
  modport master (
    output start, rows,
    input  busy, done, w_rd_en, w_addr, d_rd_en, d_addr,
           load_weight, swap_weights, run, acc_valid, acc_row, cycle_count
  );

  modport slave (
    input  start, rows,
    output busy, done, w_rd_en, w_addr, d_rd_en, d_addr,
           load_weight, swap_weights, run, acc_valid, acc_row, cycle_count
  );
`else
  modport master (
    output start, rows,
    input  busy, done, w_rd_en, w_addr, d_rd_en, d_addr,
           load_weight, swap_weights, run, acc_valid, acc_row
  );

  modport slave (
    input  start, rows,
    output busy, done, w_rd_en, w_addr, d_rd_en, d_addr,
           load_weight, swap_weights, run, acc_valid, acc_row
  );
`endif

endinterface

// File: rtl/systolic_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_ctrl
// Purpose : sequences one matrix job on an N x N weight-stationary systolic
//           array: loads the N weight rows (bottom row first), swaps them
//           into the active weight registers, streams M data vectors, keeps
//           the array running through skew and drain, and flags each
//           finished result row at the bottom of the array.
// Ports   : clk   - single clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - systolic_ctrl_if.slave (start/rows in; status, memory
//                   read strobes/addresses and array controls out)
// Params  : N     - array dimension (N >= 2)
//           ROW_W - width of the row count and data/result addresses
// Option  : SYSTOLIC_CTRL_PERF_EN - when defined, adds bus.cycle_count, a
//           saturating count of busy cycles for the last job.
// ---------------------------------------------------------------------------
module systolic_ctrl #(
  parameter int N     = 4,
  parameter int ROW_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  systolic_ctrl_if.slave bus
);

  localparam int AW = $clog2(N);
  // Phase counter must reach 2N + M - 1 with M up to 2^ROW_W - 1.
  localparam int CW = ROW_W + $clog2(N) + 3;
  localparam logic [CW-1:0] LOAD_LAST = CW'(N - 1);
  localparam logic [CW-1:0] SKEW      = CW'(2 * N);

  typedef enum logic [2:0] {IDLE, LOAD, SWAP, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [ROW_W-1:0] r_rows;
  logic [CW-1:0]    w_rows_ext;
  logic             w_accept;

  // Next-cycle output values decoded from the current state.
  logic             w_nxt_busy;
  logic             w_nxt_done;
  logic             w_nxt_w_rd_en;
  logic [AW-1:0]    w_nxt_w_addr;
  logic             w_nxt_d_rd_en;
  logic [ROW_W-1:0] w_nxt_d_addr;
  logic             w_nxt_swap;
  logic             w_nxt_run;
  logic             w_nxt_acc_valid;
  logic [ROW_W-1:0] w_nxt_acc_row;

  logic             r_busy;
  logic             r_done;
  logic             r_w_rd_en;
  logic [AW-1:0]    r_w_addr;
  logic             r_d_rd_en;
  logic [ROW_W-1:0] r_d_addr;
  logic             r_load_weight;
  logic             r_swap;
  logic             r_run;
  logic             r_acc_valid;
  logic [ROW_W-1:0] r_acc_row;

  assign w_accept   = (r_state == IDLE) && bus.start;
  assign w_rows_ext = {{(CW - ROW_W){1'b0}}, r_rows};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rows  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_rows <= bus.rows;
      end
    end
  end

  // All outputs are registered, so the decode below produces the values for
  // the cycle after the current one. LOAD lasts N cycles, SWAP two cycles
  // (covers the trailing load_weight and then the swap), RUN lasts 2N + M
  // cycles relative to the end of SWAP, DONE one cycle. A start arriving
  // while DONE is being left is ignored because only IDLE samples it.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt + CW'(1);
    w_nxt_busy      = (r_state != IDLE);
    w_nxt_done      = 1'b0;
    w_nxt_w_rd_en   = 1'b0;
    w_nxt_w_addr    = '0;
    w_nxt_d_rd_en   = 1'b0;
    w_nxt_d_addr    = '0;
    w_nxt_swap      = 1'b0;
    w_nxt_run       = 1'b0;
    w_nxt_acc_valid = 1'b0;
    w_nxt_acc_row   = '0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (bus.start) begin
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        // Bottom weight row is fetched first so it ends up deepest.
        w_nxt_w_rd_en = 1'b1;
        w_nxt_w_addr  = AW'(N - 1) - r_cnt[AW-1:0];
        if (r_cnt == LOAD_LAST) begin
          w_state_nxt = SWAP;
          w_cnt_nxt   = '0;
        end
      end
      SWAP: begin
        if (r_cnt == CW'(1)) begin
          w_nxt_swap  = 1'b1;
          w_state_nxt = (r_rows == '0) ? DONE : RUN;
          w_cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (r_cnt < w_rows_ext) begin
          w_nxt_d_rd_en = 1'b1;
          w_nxt_d_addr  = r_cnt[ROW_W-1:0];
        end
        // run starts one cycle after the first data read (read latency)
        // and keeps going until the last result has drained.
        w_nxt_run = (r_cnt != '0);
        if (r_cnt >= SKEW) begin
          w_nxt_acc_valid = 1'b1;
          w_nxt_acc_row   = ROW_W'(r_cnt - SKEW);
        end
        if (r_cnt == SKEW + w_rows_ext - CW'(1)) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
        end
      end
      DONE: begin
        w_nxt_done  = 1'b1;
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // load_weight follows w_rd_en by one cycle to match the memory latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_w_rd_en     <= 1'b0;
      r_w_addr      <= '0;
      r_d_rd_en     <= 1'b0;
      r_d_addr      <= '0;
      r_load_weight <= 1'b0;
      r_swap        <= 1'b0;
      r_run         <= 1'b0;
      r_acc_valid   <= 1'b0;
      r_acc_row     <= '0;
    end else begin
      r_busy        <= w_nxt_busy;
      r_done        <= w_nxt_done;
      r_w_rd_en     <= w_nxt_w_rd_en;
      r_w_addr      <= w_nxt_w_addr;
      r_d_rd_en     <= w_nxt_d_rd_en;
      r_d_addr      <= w_nxt_d_addr;
      r_load_weight <= r_w_rd_en;
      r_swap        <= w_nxt_swap;
      r_run         <= w_nxt_run;
      r_acc_valid   <= w_nxt_acc_valid;
      r_acc_row     <= w_nxt_acc_row;
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.w_rd_en      = r_w_rd_en;
  assign bus.w_addr       = r_w_addr;
  assign bus.d_rd_en      = r_d_rd_en;
  assign bus.d_addr       = r_d_addr;
  assign bus.load_weight  = r_load_weight;
  assign bus.swap_weights = r_swap;
  assign bus.run          = r_run;
  assign bus.acc_valid    = r_acc_valid;
  assign bus.acc_row      = r_acc_row;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] r_cycle_count;

  // Counts on every edge that makes busy high, so the count already equals
  // the job length while done is visible; it then holds until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_count <= '0;
    end else if (w_accept) begin
      r_cycle_count <= '0;
    end else if (w_nxt_busy && (r_cycle_count != '1)) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign bus.cycle_count = r_cycle_count;
`endif

endmodule
